// File: rtl/mem_stage_ls.sv
// mem_stage_ls: memory-access pipeline stage between EX/MEM and MEM/WB.
//
// Performs byte/half/word loads and stores against an internal little-endian
// data memory with WAIT_STATES extra cycles per access. It stalls upstream
// while an access is in flight, then registers the MEM/WB bundle, including
// sign- or zero-extended load data.
//
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   : a misaligned access completes at once with out_misalign=1,
//               writeback disabled, load data 0 and the store suppressed.
//   undefined : the lane offset is aligned down to the access size and
//               out_misalign stays 0.
//
// Ports:
//   clk, reset       rising-edge clock; synchronous active-low reset
//   in_*             EX/MEM bundle (valid, ir, alu_out/address, store data,
//                    load/store, size, unsigned, reg_write)
//   flush            kill the op being presented or in flight
//   stall_out        upstream holds in_* stable while high
//   out_*            MEM/WB registers
//   dbg_addr/data    combinational read of one memory word
//   dbg_state        current FSM state (1 = WAIT)
//
// Handshake: an op is taken when in_valid is high and stall_out is low at a
// rising edge; while stall_out is high, upstream keeps every in_* stable.
module mem_stage_ls #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_ir,
  input  logic [XLEN-1:0]          in_alu_out,
  input  logic [XLEN-1:0]          in_store_data,
  input  logic                     in_load,
  input  logic                     in_store,
  input  logic [1:0]               in_size,
  input  logic                     in_unsigned,
  input  logic                     in_reg_write,
  input  logic                     flush,
  output logic                     stall_out,
  output logic                     out_valid,
  output logic [31:0]              out_ir,
  output logic [XLEN-1:0]          out_alu_out,
  output logic [XLEN-1:0]          out_load_data,
  output logic                     out_load,
  output logic                     out_reg_write,
  output logic                     out_misalign,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic                     dbg_state
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int IB = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [XLEN-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_ir_q, out_ir_d;
  logic [XLEN-1:0] out_alu_out_q, out_alu_out_d;
  logic [XLEN-1:0] out_load_data_q, out_load_data_d;
  logic            out_load_q, out_load_d;
  logic            out_reg_write_q, out_reg_write_d;
  logic            out_misalign_q, out_misalign_d;

  logic            is_mem, is_load, is_store;
  logic [LB-1:0]   lane_off, off_mask, off_al;
  logic            mis_raw, trap;
  logic [IB-1:0]   word_idx;
  logic [NB-1:0]   be_base, be;
  logic [XLEN-1:0] wdata, rshift, ext, load_result;
  logic            stall, complete, mem_we;

  // Address bits above the memory size are ignored so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^in_alu_out[XLEN-1:IB+LB];

  // Load wins when both load and store are raised.
  assign is_mem   = in_load | in_store;
  assign is_load  = in_load;
  assign is_store = in_store & ~in_load;
  assign lane_off = in_alu_out[LB-1:0];
  assign word_idx = in_alu_out[IB+LB-1:LB];

  assign mis_raw = is_mem & (((in_size == 2'b01) & lane_off[0]) |
                             (in_size[1] & (|lane_off)));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap = mis_raw;
`else
  assign trap = 1'b0;
`endif

  // Offset bits below the access size are cleared (aligns down); for
  // aligned accesses this leaves the offset unchanged.
  always_comb begin
    off_mask = '0;
    be_base  = '0;
    case (in_size)
      2'b00: begin
        off_mask = '0;
        be_base  = NB'(1);
      end
      2'b01: begin
        off_mask = LB'(1);
        be_base  = NB'(3);
      end
      default: begin
        off_mask = '1;
        be_base  = '1;
      end
    endcase
  end

  assign off_al = lane_off & ~off_mask;
  assign be     = be_base << off_al;
  assign wdata  = in_store_data << {off_al, 3'b000};
  assign rshift = mem[word_idx] >> {off_al, 3'b000};

  always_comb begin
    ext = rshift;
    case (in_size)
      2'b00: ext = in_unsigned ? XLEN'(rshift[7:0])
                               : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      2'b01: ext = in_unsigned ? XLEN'(rshift[15:0])
                               : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      default: ext = rshift;
    endcase
  end

  assign load_result = is_load ? ext : '0;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall           = 1'b0;
    complete        = 1'b0;
    out_valid_d     = 1'b0;
    out_ir_d        = out_ir_q;
    out_alu_out_d   = out_alu_out_q;
    out_load_data_d = out_load_data_q;
    out_load_d      = out_load_q;
    out_reg_write_d = out_reg_write_q;
    out_misalign_d  = out_misalign_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_mem || trap || (WAIT_STATES == 0)) begin
              complete = 1'b1;
            end else begin
              // First stall cycle is the presentation cycle itself.
              stall   = 1'b1;
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
          end else begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (complete) begin
      out_valid_d     = 1'b1;
      out_ir_d        = in_ir;
      out_alu_out_d   = in_alu_out;
      out_load_d      = in_load;
      out_reg_write_d = in_reg_write & ~trap;
      out_misalign_d  = trap;
      out_load_data_d = trap ? '0 : load_result;
    end
  end

  assign mem_we = reset & complete & is_store & ~trap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      out_valid_q     <= 1'b0;
      out_ir_q        <= '0;
      out_alu_out_q   <= '0;
      out_load_data_q <= '0;
      out_load_q      <= 1'b0;
      out_reg_write_q <= 1'b0;
      out_misalign_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      out_valid_q     <= out_valid_d;
      out_ir_q        <= out_ir_d;
      out_alu_out_q   <= out_alu_out_d;
      out_load_data_q <= out_load_data_d;
      out_load_q      <= out_load_d;
      out_reg_write_q <= out_reg_write_d;
      out_misalign_q  <= out_misalign_d;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign stall_out     = stall & reset;
  assign out_valid     = out_valid_q;
  assign out_ir        = out_ir_q;
  assign out_alu_out   = out_alu_out_q;
  assign out_load_data = out_load_data_q;
  assign out_load      = out_load_q;
  assign out_reg_write = out_reg_write_q;
  assign out_misalign  = out_misalign_q;
  assign dbg_data      = mem[dbg_addr];
  assign dbg_state     = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: one instance with no wait states driven from a
// vector table, one with three wait states driven by hand-written sequences
// for stall timing, flush and reset-in-WAIT.
module tb_mem_stage_ls;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel3 = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ir = '0;
  logic [31:0] in_alu_out = '0;
  logic [31:0] in_store_data = '0;
  logic        in_load = 1'b0;
  logic        in_store = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic        in_reg_write = 1'b0;
  logic        flush = 1'b0;
  logic [10:0] dbg_addr = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic        o0_stall, o0_valid, o0_load, o0_rw, o0_mis, o0_state;
  logic [31:0] o0_ir, o0_alu, o0_data, o0_dbg;
  logic        o3_stall, o3_valid, o3_load, o3_rw, o3_mis, o3_state;
  logic [31:0] o3_ir, o3_alu, o3_data, o3_dbg;

  mem_stage_ls #(.XLEN(32), .DEPTH(2048), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel3), .in_ir(in_ir),
    .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_load(in_load),
    .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_reg_write(in_reg_write), .flush(flush & ~sel3), .stall_out(o0_stall),
    .out_valid(o0_valid), .out_ir(o0_ir), .out_alu_out(o0_alu),
    .out_load_data(o0_data), .out_load(o0_load), .out_reg_write(o0_rw),
    .out_misalign(o0_mis), .dbg_addr(dbg_addr), .dbg_data(o0_dbg),
    .dbg_state(o0_state)
  );

  mem_stage_ls #(.XLEN(32), .DEPTH(2048), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel3), .in_ir(in_ir),
    .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_load(in_load),
    .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_reg_write(in_reg_write), .flush(flush & sel3), .stall_out(o3_stall),
    .out_valid(o3_valid), .out_ir(o3_ir), .out_alu_out(o3_alu),
    .out_load_data(o3_data), .out_load(o3_load), .out_reg_write(o3_rw),
    .out_misalign(o3_mis), .dbg_addr(dbg_addr), .dbg_data(o3_dbg),
    .dbg_state(o3_state)
  );

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [10:0] dba;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_mis;
    logic [31:0] exp_dbg;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                              input logic uns, input logic rw, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [10:0] dba,
                              input logic [31:0] exp_data, input logic exp_rw,
                              input logic exp_mis, input logic [31:0] exp_dbg);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.rw = rw; v.addr = addr;
    v.sdata = sdata; v.dba = dba; v.exp_data = exp_data; v.exp_rw = exp_rw;
    v.exp_mis = exp_mis; v.exp_dbg = exp_dbg;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic rw, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] ir);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_reg_write = rw; in_alu_out = addr; in_store_data = sdata; in_ir = ir;
  endtask

  // Presents one op to the wait-state instance and follows it to completion.
  task automatic run3(input string name, input logic ld, input logic st,
                      input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] ir,
                      input int exp_stalls, input logic [31:0] exp_data,
                      input logic exp_mis);
    int  stalls;
    bit  done;
    stalls = 0;
    done = 1'b0;
    @(negedge clk);
    drive(ld, st, sz, uns, 1'b1, addr, sdata, ir);
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (o3_stall === 1'b1) begin
        stalls++;
        if (stalls > 1) check({name, " bubble"}, 32'(o3_valid), 32'd0);
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) check({name, " stall timeout"}, 32'(stalls), 32'(exp_stalls));
    check({name, " stall count"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    #1;
    check({name, " valid"}, 32'(o3_valid), 32'd1);
    check({name, " ir"}, o3_ir, ir);
    check({name, " misalign"}, 32'(o3_mis), 32'(exp_mis));
    if (ld) check({name, " data"}, o3_data, exp_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(0, 1, 2'b10, 0, 0, 32'h0000, 32'h0000_0000, 11'd0, 32'h0, 0, 0, 32'h0000_0000);
    vt[1]  = mk(0, 1, 2'b10, 0, 0, 32'h0020, 32'h0000_0000, 11'd8, 32'h0, 0, 0, 32'h0000_0000);
    vt[2]  = mk(0, 1, 2'b10, 0, 0, 32'h0010, 32'hDEAD_BEEF, 11'd4, 32'h0, 0, 0, 32'hDEAD_BEEF);
    vt[3]  = mk(1, 0, 2'b10, 0, 1, 32'h0010, 32'h0, 11'd4, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF);
    vt[4]  = mk(1, 0, 2'b00, 0, 1, 32'h0013, 32'h0, 11'd4, 32'hFFFF_FFDE, 1, 0, 32'hDEAD_BEEF);
    vt[5]  = mk(1, 0, 2'b00, 1, 1, 32'h0013, 32'h0, 11'd4, 32'h0000_00DE, 1, 0, 32'hDEAD_BEEF);
    vt[6]  = mk(1, 0, 2'b01, 0, 1, 32'h0012, 32'h0, 11'd4, 32'hFFFF_DEAD, 1, 0, 32'hDEAD_BEEF);
    vt[7]  = mk(1, 0, 2'b01, 1, 1, 32'h0010, 32'h0, 11'd4, 32'h0000_BEEF, 1, 0, 32'hDEAD_BEEF);
    vt[8]  = mk(1, 0, 2'b00, 0, 1, 32'h0011, 32'h0, 11'd4, 32'hFFFF_FFBE, 1, 0, 32'hDEAD_BEEF);
    vt[9]  = mk(0, 0, 2'b10, 0, 1, 32'h1234, 32'h0, 11'd4, 32'h0000_0000, 1, 0, 32'hDEAD_BEEF);
    vt[10] = mk(0, 1, 2'b00, 0, 0, 32'h0011, 32'h1234_5655, 11'd4, 32'h0, 0, 0, 32'hDEAD_55EF);
    vt[11] = mk(0, 1, 2'b01, 0, 0, 32'h0012, 32'hAAAA_7FFF, 11'd4, 32'h0, 0, 0, 32'h7FFF_55EF);
    vt[12] = mk(1, 0, 2'b01, 0, 1, 32'h0012, 32'h0, 11'd4, 32'h0000_7FFF, 1, 0, 32'h7FFF_55EF);
    vt[13] = mk(0, 1, 2'b00, 0, 0, 32'h2001, 32'h0000_00AA, 11'd0, 32'h0, 0, 0, 32'h0000_AA00);
    vt[14] = mk(1, 0, 2'b10, 0, 1, 32'h0000, 32'h0, 11'd0, 32'h0000_AA00, 1, 0, 32'h0000_AA00);
    if (TRAP) begin
      vt[15] = mk(0, 1, 2'b01, 0, 1, 32'h0021, 32'h0000_BEEF, 11'd8, 32'h0, 0, 1, 32'h0000_0000);
      vt[16] = mk(1, 0, 2'b10, 0, 1, 32'h0012, 32'h0, 11'd4, 32'h0000_0000, 0, 1, 32'h7FFF_55EF);
    end else begin
      vt[15] = mk(0, 1, 2'b01, 0, 1, 32'h0021, 32'h0000_BEEF, 11'd8, 32'h0, 1, 0, 32'h0000_BEEF);
      vt[16] = mk(1, 0, 2'b10, 0, 1, 32'h0012, 32'h0, 11'd4, 32'h7FFF_55EF, 1, 0, 32'h7FFF_55EF);
    end
    vt[17] = mk(1, 0, 2'b11, 0, 1, 32'h0010, 32'h0, 11'd4, 32'h7FFF_55EF, 1, 0, 32'h7FFF_55EF);
    vt[18] = mk(1, 1, 2'b10, 0, 1, 32'h0010, 32'h0, 11'd4, 32'h7FFF_55EF, 1, 0, 32'h7FFF_55EF);

    // Clock/reset: hold reset low for a few edges and check cleared outputs.
    repeat (3) @(posedge clk);
    #1;
    check("rst stall0", 32'(o0_stall), 32'd0);
    check("rst valid0", 32'(o0_valid), 32'd0);
    check("rst ir0", o0_ir, 32'd0);
    check("rst alu0", o0_alu, 32'd0);
    check("rst data0", o0_data, 32'd0);
    check("rst rw0", 32'(o0_rw), 32'd0);
    check("rst valid3", 32'(o3_valid), 32'd0);
    check("rst state3", 32'(o3_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors on the zero-wait-state instance.
    sel3 = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].ld, vt[i].st, vt[i].sz, vt[i].uns, vt[i].rw, vt[i].addr,
            vt[i].sdata, 32'h1000 + 32'(i));
      dbg_addr = vt[i].dba;
      #1;
      check($sformatf("v%0d stall", i), 32'(o0_stall), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), 32'(o0_valid), 32'd1);
      check($sformatf("v%0d ir", i), o0_ir, 32'h1000 + 32'(i));
      check($sformatf("v%0d alu", i), o0_alu, vt[i].addr);
      check($sformatf("v%0d rw", i), 32'(o0_rw), 32'(vt[i].exp_rw));
      check($sformatf("v%0d misalign", i), 32'(o0_mis), 32'(vt[i].exp_mis));
      check($sformatf("v%0d dbg", i), o0_dbg, vt[i].exp_dbg);
      if (vt[i].ld || !vt[i].st)
        check($sformatf("v%0d data", i), o0_data, vt[i].exp_data);
    end

    // Idle cycle: valid drops, the rest of the bundle holds.
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle valid", 32'(o0_valid), 32'd0);
    check("idle ir hold", o0_ir, 32'h1000 + 32'(NV - 1));
    check("idle data hold", o0_data, 32'h7FFF_55EF);

    // Three-wait-state instance: stall length, bubbles, back-to-back ops.
    sel3 = 1'b1;
    run3("st3", 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h3001, 3, 32'h0, 1'b0);
    run3("ld3", 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h3002, 3, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h5555, 32'h0, 32'h3003);
    #1;
    check("alu3 stall", 32'(o3_stall), 32'd0);
    @(posedge clk);
    #1;
    check("alu3 valid", 32'(o3_valid), 32'd1);
    check("alu3 ir", o3_ir, 32'h3003);
    check("alu3 data", o3_data, 32'd0);
    run3("mis3", 1'b1, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 32'h3004,
         TRAP ? 0 : 3, TRAP ? 32'h0 : 32'hFFFF_F00D, TRAP);
    run3("clr3", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h3005, 3, 32'h0, 1'b0);

    // Flush in the second stall cycle of a store: no write, back to IDLE.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'h1122_3344, 32'h3006);
    dbg_addr = 11'd8;
    #1;
    check("fl first stall", 32'(o3_stall), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl stall low", 32'(o3_stall), 32'd0);
    @(posedge clk);
    #1;
    check("fl valid", 32'(o3_valid), 32'd0);
    check("fl state", 32'(o3_state), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fl mem unchanged", o3_dbg, 32'd0);

    // Reset while in WAIT: outputs clear, access abandoned.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h20, 32'h5566_7788, 32'h3007);
    @(negedge clk);
    check("rw wait state", 32'(o3_state), 32'd1);
    reset = 1'b0;
    #1;
    check("rw stall low", 32'(o3_stall), 32'd0);
    @(posedge clk);
    #1;
    check("rw valid", 32'(o3_valid), 32'd0);
    check("rw ir", o3_ir, 32'd0);
    check("rw alu", o3_alu, 32'd0);
    check("rw data", o3_data, 32'd0);
    check("rw load", 32'(o3_load), 32'd0);
    check("rw regwr", 32'(o3_rw), 32'd0);
    check("rw misalign", 32'(o3_mis), 32'd0);
    check("rw state", 32'(o3_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rw mem unchanged", o3_dbg, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
